sobel_edge_filter: RTL

//  Full 3x3 Sobel edge detector on the grayscale pixel stream read from the frame buffer.

---
 rtl/sobel_edge_filter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sobel_edge_filter.sv
// 3x3 Sobel edge detector for the VGA grayscale stream: two line buffers, a 3x3 window
// and a three-stage pipeline producing one saturated edge magnitude per input pixel.
module sobel_edge_filter #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int MAG_SHIFT  = 0
) (
    input  logic       CLK25,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       pix_valid,
    input  logic [7:0] gray_in,
    output logic [7:0] edge_out,
    output logic       edge_valid,
    output logic       frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    localparam logic [1:0] WAIT_FRAME = 2'd0;
    localparam logic [1:0] STREAM     = 2'd1;
    localparam logic [1:0] FRAME_DONE = 2'd2;

    function automatic logic [10:0] abs11(input logic [10:0] v);
        logic [10:0] r;
        if (v[10]) begin
            r = ~v + 11'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          frame_done_q, frame_done_d;

    logic [7:0] lb0_mem [IMG_WIDTH];
    logic [7:0] lb1_mem [IMG_WIDTH];
    logic [7:0] lb0_rd_s, lb1_rd_s;
    logic       accept_s;

    // window indexed [row][col]: row 0 = two lines up, col 2 = newest column
    logic [2:0][2:0][7:0] win_q, win_d;
    logic                 v1_q, v1_d, z1_q, z1_d;
    logic [10:0]          gx_q, gx_d, gy_q, gy_d;
    logic                 v2_q, v2_d, z2_q, z2_d;
    logic [9:0]           gx_pos_s, gx_neg_s, gy_pos_s, gy_neg_s;
    logic [11:0]          mag_s, mag_sh_s;
    logic [7:0]           edge_out_q, edge_out_d;
    logic                 edge_valid_q, edge_valid_d;

    assign accept_s = pix_valid && (state_q == STREAM);
    assign lb0_rd_s = lb0_mem[col_q];
    assign lb1_rd_s = lb1_mem[col_q];

    // Frame position counters and frame state
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = frame_done_q;
        if (!vsync) begin
            state_d      = WAIT_FRAME;
            col_d        = {CW{1'b0}};
            row_d        = {RW{1'b0}};
            frame_done_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_FRAME: begin
                    state_d      = STREAM;
                    col_d        = {CW{1'b0}};
                    row_d        = {RW{1'b0}};
                    frame_done_d = 1'b0;
                end
                STREAM: begin
                    if (pix_valid) begin
                        if (col_q == COL_LAST) begin
                            col_d = {CW{1'b0}};
                            if (row_q == ROW_LAST) begin
                                state_d      = FRAME_DONE;
                                row_d        = {RW{1'b0}};
                                frame_done_d = 1'b1;
                            end else begin
                                row_d = row_q + RW'(1);
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        state_d = STREAM;
                    end
                end
                FRAME_DONE: frame_done_d = 1'b1;
                default:    state_d = WAIT_FRAME;
            endcase
        end
    end

    // Stage 1: window shift; border flag masks rows/cols whose window is not yet filled
    always_comb begin
        win_d = win_q;
        v1_d  = pix_valid;
        if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd_s;
            win_d[1][2] = lb0_rd_s;
            win_d[2][2] = gray_in;
            z1_d = (row_q < RW'(2)) || (col_q < CW'(2));
        end else begin
            z1_d = 1'b1;
        end
    end

    // Stage 2: gradients as 11-bit two's complement
    always_comb begin
        gx_pos_s = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
        gx_neg_s = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
        gy_pos_s = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
        gy_neg_s = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};
        gx_d = {1'b0, gx_pos_s} - {1'b0, gx_neg_s};
        gy_d = {1'b0, gy_pos_s} - {1'b0, gy_neg_s};
        v2_d = v1_q;
        z2_d = z1_q;
    end

    // Stage 3: magnitude, shift and saturation
    always_comb begin
        mag_s        = {1'b0, abs11(gx_q)} + {1'b0, abs11(gy_q)};
        mag_sh_s     = mag_s >> MAG_SHIFT;
        edge_valid_d = v2_q;
        if (!v2_q || z2_q) begin
            edge_out_d = 8'd0;
        end else if (mag_sh_s > 12'd255) begin
            edge_out_d = 8'hFF;
        end else begin
            edge_out_d = mag_sh_s[7:0];
        end
    end

    // Line buffers: read-before-write, contents need no reset
    always_ff @(posedge CLK25) begin
        if (accept_s) begin
            lb1_mem[col_q] <= lb0_rd_s;
            lb0_mem[col_q] <= gray_in;
        end
    end

    // Control and pipeline registers
    always_ff @(posedge CLK25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_FRAME;
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            frame_done_q <= 1'b0;
            win_q        <= '0;
            v1_q         <= 1'b0;
            z1_q         <= 1'b1;
            gx_q         <= 11'd0;
            gy_q         <= 11'd0;
            v2_q         <= 1'b0;
            z2_q         <= 1'b1;
            edge_out_q   <= 8'd0;
            edge_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
            v1_q         <= v1_d;
            z1_q         <= z1_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            v2_q         <= v2_d;
            z2_q         <= z2_d;
            edge_out_q   <= edge_out_d;
            edge_valid_q <= edge_valid_d;
        end
    end

    assign edge_out   = edge_out_q;
    assign edge_valid = edge_valid_q;
    assign frame_done = frame_done_q;

endmodule
